data_mem_arbiter: RTL and testbench

//  Shares the single-port, synchronous-read data memory between the CPU load/store stage (requester 0)
//  and a debug/loader port (requester 1). Issues one registered memory command per cycle and routes

---
 rtl/data_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-port data memory (CPU vs debug/loader), with debug lock and starvation bound.
// Define DATA_MEM_ARB_PERF_EN to build the CPU stall-cycle counter; otherwise o_stall_cycles is tied to zero.
module data_mem_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_cpu_req,
   input  logic                      i_cpu_we,
   input  logic [ADDR_WIDTH-1:0]     i_cpu_addr,
   input  logic [DATA_WIDTH-1:0]     i_cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_cpu_be,
   output logic                      o_cpu_gnt,
   output logic                      o_cpu_stall,
   output logic                      o_cpu_rvalid,
   output logic [DATA_WIDTH-1:0]     o_cpu_rdata,
   input  logic                      i_dbg_req,
   input  logic                      i_dbg_we,
   input  logic [ADDR_WIDTH-1:0]     i_dbg_addr,
   input  logic [DATA_WIDTH-1:0]     i_dbg_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_dbg_be,
   input  logic                      i_dbg_lock,
   output logic                      o_dbg_gnt,
   output logic                      o_dbg_rvalid,
   output logic [DATA_WIDTH-1:0]     o_dbg_rdata,
   output logic                      o_mem_en,
   output logic                      o_mem_we,
   output logic [ADDR_WIDTH-1:0]     o_mem_addr,
   output logic [DATA_WIDTH-1:0]     o_mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   o_mem_be,
   input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
   output logic [31:0]               o_stall_cycles
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [0:0] {ARB, DBG_LOCKED} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        starve_cnt;
   logic                    arb_mode;
   logic                    dbg_starving;
   logic                    cpu_gnt;
   logic                    dbg_gnt;
   logic                    rd_tag_cpu;
   logic                    rd_tag_dbg;
   logic [DATA_WIDTH-1:0]   cpu_rdata_q;
   logic [DATA_WIDTH-1:0]   dbg_rdata_q;

   // Dropping the lock while locked re-opens normal arbitration in that same cycle.
   assign arb_mode     = (state == ARB) || !i_dbg_lock;
   assign dbg_starving = (starve_cnt == CNT_W'(STARVE_LIMIT));

   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (!i_reset) begin
         if (!arb_mode)
            dbg_gnt = i_dbg_req;
         else if (dbg_starving && i_dbg_req)
            dbg_gnt = 1'b1;
         else if (i_cpu_req)
            cpu_gnt = 1'b1;
         else if (i_dbg_req)
            dbg_gnt = 1'b1;
      end
   end

   assign o_cpu_gnt   = cpu_gnt;
   assign o_dbg_gnt   = dbg_gnt;
   assign o_cpu_stall = i_cpu_req && !cpu_gnt && !i_reset;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= ARB;
         starve_cnt <= '0;
      end else begin
         if (i_dbg_lock && ((state == DBG_LOCKED) || dbg_gnt))
            state <= DBG_LOCKED;
         else
            state <= ARB;

         if (i_dbg_req && !dbg_gnt) begin
            if (!dbg_starving)
               starve_cnt <= starve_cnt + CNT_W'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_mem_en     <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_wdata  <= '0;
         o_mem_be     <= '0;
         rd_tag_cpu   <= 1'b0;
         rd_tag_dbg   <= 1'b0;
         o_cpu_rvalid <= 1'b0;
         o_dbg_rvalid <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         o_mem_en <= cpu_gnt || dbg_gnt;
         if (cpu_gnt) begin
            o_mem_we    <= i_cpu_we;
            o_mem_addr  <= i_cpu_addr;
            o_mem_wdata <= i_cpu_wdata;
            o_mem_be    <= i_cpu_be;
         end else if (dbg_gnt) begin
            o_mem_we    <= i_dbg_we;
            o_mem_addr  <= i_dbg_addr;
            o_mem_wdata <= i_dbg_wdata;
            o_mem_be    <= i_dbg_be;
         end else begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
         end

         // Owner tag travels alongside the command, then alongside the memory's read latency.
         rd_tag_cpu   <= cpu_gnt && !i_cpu_we;
         rd_tag_dbg   <= dbg_gnt && !i_dbg_we;
         o_cpu_rvalid <= rd_tag_cpu;
         o_dbg_rvalid <= rd_tag_dbg;

         if (o_cpu_rvalid)
            cpu_rdata_q <= i_mem_rdata;
         if (o_dbg_rvalid)
            dbg_rdata_q <= i_mem_rdata;
      end
   end

   // Read data is live from memory in the valid cycle and held afterwards.
   assign o_cpu_rdata = o_cpu_rvalid ? i_mem_rdata : cpu_rdata_q;
   assign o_dbg_rdata = o_dbg_rvalid ? i_mem_rdata : dbg_rdata_q;

`ifdef DATA_MEM_ARB_PERF_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         stall_cnt <= '0;
      else if (o_cpu_stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign o_stall_cycles = stall_cnt;
`else
   assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: arbitration table plus hand sequences for pipeline, lock, reset and perf counter.
module tb_data_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [4:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_be;
   logic        cpu_gnt, cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dbg_req, dbg_we, dbg_lock;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic [3:0]  dbg_be;
   logic        dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        mem_en, mem_we;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic [31:0] stall_cycles;

   int unsigned n_pass;
   int unsigned n_total;

   data_mem_arbiter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5),
      .STARVE_LIMIT(4)
   ) dut (
      .i_clk(clk), .i_reset(rst),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
      .i_cpu_wdata(cpu_wdata), .i_cpu_be(cpu_be),
      .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall),
      .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_wdata(dbg_wdata), .i_dbg_be(dbg_be), .i_dbg_lock(dbg_lock),
      .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_rdata(mem_rdata),
      .o_stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory; each word preloads to 1000_0000 + address on reset.
   logic [31:0] mem [0:31];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   typedef struct {
      logic        c_req;
      logic        d_req;
      logic        d_lock;
      logic [4:0]  d_addr;
      logic [3:0]  d_be;
      logic [31:0] d_wdata;
      logic        e_cg;
      logic        e_dg;
      logic        e_st;
      logic        e_men;
   } vec_t;

   vec_t vec [0:22];

   function automatic vec_t mk(logic c, logic d, logic l, logic [4:0] a, logic [3:0] be,
                               logic [31:0] wd, logic cg, logic dg, logic st, logic men);
      vec_t v;
      v.c_req = c; v.d_req = d; v.d_lock = l; v.d_addr = a; v.d_be = be; v.d_wdata = wd;
      v.e_cg = cg; v.e_dg = dg; v.e_st = st; v.e_men = men;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_be = '0;
      dbg_lock = 1'b0;
   endtask

   task automatic cpu_load(input logic [4:0] a);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = '0; cpu_be = 4'hF;
   endtask

   logic [31:0] exp_stall;

   initial begin
      n_pass = 0;
      n_total = 0;
`ifdef DATA_MEM_ARB_PERF_EN
      exp_stall = 32'd7;
`else
      exp_stall = 32'd0;
`endif
      for (int i = 0; i < 14; i++) begin
         if (i == 4 || i == 9)
            vec[i] = mk(1'b1, 1'b1, 1'b0, 5'd7, 4'hF, 32'h7777_7777, 1'b0, 1'b1, 1'b1, 1'b1);
         else
            vec[i] = mk(1'b1, 1'b1, 1'b0, 5'd7, 4'hF, 32'h7777_7777, 1'b1, 1'b0, 1'b0, (i != 0));
      end
      vec[14] = mk(1'b1, 1'b1, 1'b1, 5'd0, 4'hF, 32'hA000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
      vec[15] = mk(1'b1, 1'b1, 1'b1, 5'd1, 4'hF, 32'hA000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
      vec[16] = mk(1'b1, 1'b0, 1'b1, 5'd0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1);
      vec[17] = mk(1'b1, 1'b1, 1'b1, 5'd2, 4'hF, 32'hA000_0002, 1'b0, 1'b1, 1'b1, 1'b0);
      vec[18] = mk(1'b1, 1'b1, 1'b1, 5'd3, 4'hF, 32'hA000_0003, 1'b0, 1'b1, 1'b1, 1'b1);
      vec[19] = mk(1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1);
      vec[20] = mk(1'b0, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1);
      vec[21] = mk(1'b0, 1'b1, 1'b0, 5'd4, 4'h3, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
      vec[22] = mk(1'b0, 1'b0, 1'b0, 5'd0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1);

      // Reset with both requesters active: grants and stall must stay low.
      idle();
      rst = 1'b1;
      cpu_req = 1'b1;
      dbg_req = 1'b1;
      next_cycle();
      next_cycle();
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      check("rst_stall", 32'(cpu_stall), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_stall_cycles", stall_cycles, 32'd0);
      rst = 1'b0;
      idle();
      next_cycle();

      // Store then load to address 3.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 32'hDEAD_BEEF; cpu_be = 4'hF;
      #1 check("t1_store_gnt", 32'(cpu_gnt), 32'd1);
      next_cycle();
      cpu_load(5'd3);
      #1 check("t1_load_gnt", 32'(cpu_gnt), 32'd1);
      check("t1_st_mem_en", 32'(mem_en), 32'd1);
      check("t1_st_mem_we", 32'(mem_we), 32'd1);
      check("t1_st_mem_addr", 32'(mem_addr), 32'd3);
      check("t1_st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("t1_st_mem_be", 32'(mem_be), 32'hF);
      next_cycle();
      idle();
      #1 check("t1_ld_mem_en", 32'(mem_en), 32'd1);
      check("t1_ld_mem_we", 32'(mem_we), 32'd0);
      check("t1_rvalid_early", 32'(cpu_rvalid), 32'd0);
      next_cycle();
      check("t1_rvalid", 32'(cpu_rvalid), 32'd1);
      check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
      check("t1_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check("t1_mem_idle", 32'(mem_en), 32'd0);
      next_cycle();
      check("t1_rvalid_drop", 32'(cpu_rvalid), 32'd0);
      check("t1_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

      // Starvation rotation, lock burst and idle debug grant.
      for (int i = 0; i < 23; i++) begin
         cpu_req = vec[i].c_req; cpu_we = 1'b0; cpu_addr = 5'd5; cpu_wdata = '0; cpu_be = 4'hF;
         dbg_req = vec[i].d_req; dbg_we = 1'b1; dbg_lock = vec[i].d_lock;
         dbg_addr = vec[i].d_addr; dbg_be = vec[i].d_be; dbg_wdata = vec[i].d_wdata;
         #1;
         check($sformatf("vec%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vec[i].e_cg));
         check($sformatf("vec%0d_dbg_gnt", i), 32'(dbg_gnt), 32'(vec[i].e_dg));
         check($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vec[i].e_st));
         check($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vec[i].e_men));
         next_cycle();
      end
      idle();
      check("stall_cycles", stall_cycles, exp_stall);

      // Interleaved owners: CPU addr 1, debug addr 2, CPU addr 4 (partially written).
      cpu_load(5'd1);
      #1 check("t4_a_gnt", 32'(cpu_gnt), 32'd1);
      next_cycle();
      idle();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
      #1 check("t4_b_gnt", 32'(dbg_gnt), 32'd1);
      next_cycle();
      idle();
      cpu_load(5'd4);
      #1 check("t4_c_gnt", 32'(cpu_gnt), 32'd1);
      check("t4_c_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("t4_c_cpu_rdata", cpu_rdata, 32'hA000_0001);
      check("t4_c_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      next_cycle();
      idle();
      #1 check("t4_d_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
      check("t4_d_dbg_rdata", dbg_rdata, 32'hA000_0002);
      check("t4_d_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("t4_d_cpu_hold", cpu_rdata, 32'hA000_0001);
      next_cycle();
      check("t4_e_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("t4_e_cpu_rdata", cpu_rdata, 32'h1000_FFFF);
      check("t4_e_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check("t4_e_dbg_hold", dbg_rdata, 32'hA000_0002);
      next_cycle();

      // Starvation count clears when debug withdraws.
      for (int i = 0; i < 8; i++) begin
         cpu_load(5'd5);
         dbg_req = (i != 3); dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h7777_7777; dbg_be = 4'hF;
         #1 check($sformatf("starve_clr%0d_cpu_gnt", i), 32'(cpu_gnt), 32'd1);
         next_cycle();
      end
      #1 check("starve_clr_forced", 32'(dbg_gnt), 32'd1);
      idle();
      next_cycle();
      next_cycle();
      next_cycle();

      // Reset one cycle after a CPU load grant drops the read.
      cpu_load(5'd3);
      #1 check("t5_gnt", 32'(cpu_gnt), 32'd1);
      next_cycle();
      rst = 1'b1;
      dbg_req = 1'b1;
      #1 check("t5_mem_en", 32'(mem_en), 32'd0);
      check("t5_mem_addr", 32'(mem_addr), 32'd0);
      check("t5_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("t5_stall", 32'(cpu_stall), 32'd0);
      check("t5_cpu_rdata", cpu_rdata, 32'd0);
      check("t5_dbg_rdata", dbg_rdata, 32'd0);
      next_cycle();
      rst = 1'b0;
      idle();
      #1 check("t5_no_rvalid", 32'(cpu_rvalid), 32'd0);
      next_cycle();
      check("t5_no_rvalid2", 32'(cpu_rvalid), 32'd0);
      check("t5_stall_cleared", stall_cycles, 32'd0);
      cpu_load(5'd3);
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2; dbg_lock = 1'b1;
      #1 check("t5_arb_cpu_wins", 32'(cpu_gnt), 32'd1);
      check("t5_arb_dbg_denied", 32'(dbg_gnt), 32'd0);
      next_cycle();
      idle();
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
